port_wr_admit: RTL and testbench
================================

PORT_WR_ADMIT -- requirements
Module: port_wr_admit

Interface
REQ-001 Parameter: DEPTH, 32, max packets held per priority queue (2..63).
REQ-002 Parameter: TOTAL, 128, max packets held across all 8 queues of the port (DEPTH..255).
REQ-003 Reset rst_n SHALL be synchronous, active-low; clock SHALL be clk.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 wr_valid  in  1  enqueue request for one packet.
REQ-007 wr_prior  in  3  target queue of enqueue (0 = highest priority).
REQ-008 wr_accept  out  1  registered pulse: previous-cycle request admitted.
REQ-009 wr_drop  out  1  registered pulse: previous-cycle request rejected.
REQ-010 wr_drop_prior  out  3  queue of rejected request, valid with wr_drop.
REQ-011 next  in  1  dequeue pulse from read-side scheduler.
REQ-012 rd_prior  in  3  queue being dequeued, valid with next.
REQ-013 queue_available  out  8  bit i = queue i holds >=1 packet.
REQ-014 deq_err  out  1  registered pulse: previous-cycle next hit an empty queue.
REQ-015 total_cnt  out  8  packets currently held across all queues.

Function
REQ-016 Block SHALL keep one 6-bit counter cnt[i] per queue plus total_cnt.
REQ-017 Request admitted iff wr_valid & (cnt[wr_prior] < DEPTH or same-cycle valid dequeue of wr_prior) & (total_cnt < TOTAL or same-cycle valid dequeue of any queue).
REQ-018 Admitted request: cnt[wr_prior] +1 and total_cnt +1 at same edge; wr_accept=1 for exactly the next cycle.
REQ-019 Rejected request: no counter change; wr_drop=1 and wr_drop_prior=wr_prior for exactly the next cycle.
REQ-020 Valid dequeue (next & cnt[rd_prior]!=0): cnt[rd_prior] -1, total_cnt -1 at same edge.
REQ-021 next with cnt[rd_prior]==0: no counter change; deq_err=1 next cycle.
REQ-022 Admitted enqueue + valid dequeue, same queue, same cycle: cnt and total_cnt unchanged.
REQ-023 Admitted enqueue + valid dequeue, different queues: each cnt changes by ±1; total_cnt unchanged.
REQ-024 queue_available SHALL be derived directly from counter registers (cnt[i]!=0), no extra register stage: reflects an update one edge after the causing request.
REQ-025 Counters SHALL never exceed DEPTH / TOTAL nor wrap below 0.
REQ-026 wr_accept and wr_drop SHALL never both be 1.

Reset
REQ-027 rst_n low at an edge: all cnt[i]=0, total_cnt=0, queue_available=8'h00, wr_accept=0, wr_drop=0, wr_drop_prior=0, deq_err=0; any same-cycle request ignored.
REQ-028 Reset asserted mid-operation SHALL discard all occupancy; first request after release treated as into empty queues.

Configuration
REQ-029 Macro PORT_WR_ADMIT_WATERMARK_EN: when defined, adds input wm_thresh (6 bits) and output queue_almost_full (8 bits), bit i = cnt[i] >= wm_thresh, combinational from counters like queue_available.
REQ-030 Without PORT_WR_ADMIT_WATERMARK_EN: wm_thresh and queue_almost_full ports absent; all other behaviour identical.

Verification
REQ-031 Reset, then wr_valid=1, wr_prior=3 one cycle -> wr_accept=1 next cycle, queue_available=8'h08, total_cnt=1.
REQ-032 DEPTH=32: 33 enqueues to queue 5 back-to-back -> 32 wr_accept, 33rd gives wr_drop=1, wr_drop_prior=5; cnt stays 32.
REQ-033 Queue 2 full (32), enqueue prio 2 with next=1, rd_prior=2 same cycle -> wr_accept=1, cnt[2] remains 32, total_cnt unchanged.
REQ-034 TOTAL=128 reached via 4 queues x 32; enqueue prio 7 -> wr_drop=1, drop_prior=7; with simultaneous next on queue 0 -> wr_accept=1, queue_available bit7=1.
REQ-035 Empty block, next=1, rd_prior=4 -> deq_err=1 next cycle, total_cnt stays 0, queue_available=8'h00.
REQ-036 Queue 1 holds 10 packets, rst_n low one cycle -> queue_available=8'h00, total_cnt=0; with WATERMARK_EN and wm_thresh=8 before reset, queue_almost_full bit1 falls 1->0.

Source files
------------

// File: rtl/port_wr_admit.sv
// Write-side admission control for one port: per-priority and port-wide packet occupancy counters.
// Optional macro PORT_WR_ADMIT_WATERMARK_EN adds a per-queue almost-full watermark output.
module port_wr_admit #(
    parameter int DEPTH = 32,
    parameter int TOTAL = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    input  logic [2:0] wr_prior,
    output logic       wr_accept,
    output logic       wr_drop,
    output logic [2:0] wr_drop_prior,
    input  logic       next,
    input  logic [2:0] rd_prior,
    output logic [7:0] queue_available,
    output logic       deq_err,
    output logic [7:0] total_cnt
`ifdef PORT_WR_ADMIT_WATERMARK_EN
    ,
    input  logic [5:0] wm_thresh,
    output logic [7:0] queue_almost_full
`endif
);

    localparam logic [5:0] DEPTH_C = 6'(DEPTH);
    localparam logic [7:0] TOTAL_C = 8'(TOTAL);

    logic [5:0] r_cnt [8];
    logic [7:0] r_total;
    logic       r_accept;
    logic       r_drop;
    logic [2:0] r_drop_prior;
    logic       r_deq_err;

    logic       w_deq_valid;
    logic       w_q_room;
    logic       w_t_room;
    logic       w_admit;
    logic [7:0] w_inc;
    logic [7:0] w_dec;
    logic [5:0] w_cnt_nxt [8];
    logic [7:0] w_total_nxt;

    // Admission decision; a same-cycle valid dequeue frees the slot it vacates.
    always_comb begin
        w_deq_valid = next & (r_cnt[rd_prior] != 6'd0);
        w_q_room    = (r_cnt[wr_prior] < DEPTH_C) | (w_deq_valid & (rd_prior == wr_prior));
        w_t_room    = (r_total < TOTAL_C) | w_deq_valid;
        w_admit     = wr_valid & w_q_room & w_t_room;
    end

    // Next occupancy per queue; enqueue and dequeue on the same queue cancel.
    always_comb begin
        w_inc = 8'd0;
        w_dec = 8'd0;
        for (int i = 0; i < 8; i++) begin
            w_inc[i] = w_admit & (wr_prior == 3'(i));
            w_dec[i] = w_deq_valid & (rd_prior == 3'(i));
            if (w_inc[i] && !w_dec[i]) begin
                w_cnt_nxt[i] = r_cnt[i] + 6'd1;
            end else if (!w_inc[i] && w_dec[i]) begin
                w_cnt_nxt[i] = r_cnt[i] - 6'd1;
            end else begin
                w_cnt_nxt[i] = r_cnt[i];
            end
        end
    end

    // Next port-wide occupancy.
    always_comb begin
        case ({w_admit, w_deq_valid})
            2'b10:   w_total_nxt = r_total + 8'd1;
            2'b01:   w_total_nxt = r_total - 8'd1;
            default: w_total_nxt = r_total;
        endcase
    end

    // Counter state and registered status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_cnt[i] <= 6'd0;
            end
            r_total      <= 8'd0;
            r_accept     <= 1'b0;
            r_drop       <= 1'b0;
            r_drop_prior <= 3'd0;
            r_deq_err    <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_total      <= w_total_nxt;
            r_accept     <= w_admit;
            r_drop       <= wr_valid & ~w_admit;
            r_drop_prior <= (wr_valid & ~w_admit) ? wr_prior : 3'd0;
            r_deq_err    <= next & ~w_deq_valid;
        end
    end

    // Occupancy flags come straight off the counters, no extra stage.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            queue_available[i] = (r_cnt[i] != 6'd0);
        end
    end

`ifdef PORT_WR_ADMIT_WATERMARK_EN
    // Watermark flags, also straight off the counters.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            queue_almost_full[i] = (r_cnt[i] >= wm_thresh);
        end
    end
`endif

    assign wr_accept     = r_accept;
    assign wr_drop       = r_drop;
    assign wr_drop_prior = r_drop_prior;
    assign deq_err       = r_deq_err;
    assign total_cnt     = r_total;

endmodule

// File: tb/tb_port_wr_admit.sv
// Self-checking bench for port_wr_admit: directed scenarios plus randomized traffic
// checked against an occupancy model built from the admission rules.
module tb_port_wr_admit;

    localparam int DEPTH = 32;
    localparam int TOTAL = 128;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic [2:0] wr_prior;
    logic       wr_accept;
    logic       wr_drop;
    logic [2:0] wr_drop_prior;
    logic       next;
    logic [2:0] rd_prior;
    logic [7:0] queue_available;
    logic       deq_err;
    logic [7:0] total_cnt;
`ifdef PORT_WR_ADMIT_WATERMARK_EN
    logic [5:0] wm_thresh;
    logic [7:0] queue_almost_full;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int   m_cnt [8];
    int   m_total;
    logic exp_accept;
    logic exp_drop;
    logic [2:0] exp_dprior;
    logic exp_deqerr;

    port_wr_admit #(.DEPTH(DEPTH), .TOTAL(TOTAL)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_valid       (wr_valid),
        .wr_prior       (wr_prior),
        .wr_accept      (wr_accept),
        .wr_drop        (wr_drop),
        .wr_drop_prior  (wr_drop_prior),
        .next           (next),
        .rd_prior       (rd_prior),
        .queue_available(queue_available),
        .deq_err        (deq_err),
        .total_cnt      (total_cnt)
`ifdef PORT_WR_ADMIT_WATERMARK_EN
        ,
        .wm_thresh      (wm_thresh),
        .queue_almost_full(queue_almost_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_avail();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = (m_cnt[i] > 0);
        return v;
    endfunction

`ifdef PORT_WR_ADMIT_WATERMARK_EN
    function automatic logic [7:0] model_afull();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = (m_cnt[i] >= int'(wm_thresh));
        return v;
    endfunction
`endif

    // Drive one cycle of requests, advance the model, and return 1 ns after the edge.
    task automatic do_cycle(input logic wv, input logic [2:0] wp, input logic nx, input logic [2:0] rp);
        bit deqv;
        bit adm;
        wr_valid = wv;
        wr_prior = wp;
        next     = nx;
        rd_prior = rp;
        deqv = nx && (m_cnt[rp] > 0);
        adm  = wv && ((m_cnt[wp] < DEPTH) || (deqv && rp == wp)) && ((m_total < TOTAL) || deqv);
        exp_accept = adm;
        exp_drop   = wv && !adm;
        exp_dprior = exp_drop ? wp : 3'd0;
        exp_deqerr = nx && !deqv;
        if (adm) begin
            m_cnt[wp] = m_cnt[wp] + 1;
            m_total   = m_total + 1;
        end
        if (deqv) begin
            m_cnt[rp] = m_cnt[rp] - 1;
            m_total   = m_total - 1;
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        next     = 1'b0;
    endtask

    // One reset cycle, optionally with competing requests that must be ignored.
    task automatic apply_reset(input bit with_req);
        rst_n    = 1'b0;
        wr_valid = with_req;
        wr_prior = 3'd3;
        next     = with_req;
        rd_prior = 3'd3;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        next     = 1'b0;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_total = 0;
    endtask

    task automatic test_reset();
        apply_reset(1'b1);
        n_tests++;
        if ({wr_accept, wr_drop, wr_drop_prior, deq_err} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b expected 000000", {wr_accept, wr_drop, wr_drop_prior, deq_err});
        end
        n_tests++;
        if (total_cnt !== 8'd0 || queue_available !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_counts: total=%0d avail=%h expected 0/00", total_cnt, queue_available);
        end
    endtask

    task automatic test_single_enq();
        apply_reset(1'b0);
        do_cycle(1'b1, 3'd3, 1'b0, 3'd0);
        n_tests++;
        if (wr_accept !== 1'b1 || wr_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL single_enq_accept: accept=%b drop=%b expected 1/0", wr_accept, wr_drop);
        end
        n_tests++;
        if (queue_available !== 8'h08 || total_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL single_enq_state: avail=%h total=%0d expected 08/1", queue_available, total_cnt);
        end
        do_cycle(1'b0, 3'd0, 1'b0, 3'd0);
        n_tests++;
        if (wr_accept !== 1'b0) begin
            n_fail++;
            $display("FAIL single_enq_pulse: accept=%b expected 0", wr_accept);
        end
    endtask

    task automatic test_queue_full();
        int acc;
        apply_reset(1'b0);
        acc = 0;
        for (int k = 0; k < DEPTH + 1; k++) begin
            do_cycle(1'b1, 3'd5, 1'b0, 3'd0);
            if (wr_accept === 1'b1) acc++;
        end
        n_tests++;
        if (acc != DEPTH) begin
            n_fail++;
            $display("FAIL queue_full_accepts: got %0d expected %0d", acc, DEPTH);
        end
        n_tests++;
        if (wr_drop !== 1'b1 || wr_drop_prior !== 3'd5 || wr_accept !== 1'b0) begin
            n_fail++;
            $display("FAIL queue_full_drop: drop=%b prior=%0d accept=%b expected 1/5/0", wr_drop, wr_drop_prior, wr_accept);
        end
        n_tests++;
        if (total_cnt !== 8'(DEPTH)) begin
            n_fail++;
            $display("FAIL queue_full_total: got %0d expected %0d", total_cnt, DEPTH);
        end
    endtask

    task automatic test_same_queue_deq();
        apply_reset(1'b0);
        for (int k = 0; k < DEPTH; k++) do_cycle(1'b1, 3'd2, 1'b0, 3'd0);
        do_cycle(1'b1, 3'd2, 1'b1, 3'd2);
        n_tests++;
        if (wr_accept !== 1'b1 || total_cnt !== 8'(DEPTH) || queue_available !== 8'h04) begin
            n_fail++;
            $display("FAIL same_queue_deq: accept=%b total=%0d avail=%h expected 1/%0d/04", wr_accept, total_cnt, queue_available, DEPTH);
        end
        do_cycle(1'b1, 3'd2, 1'b0, 3'd0);
        n_tests++;
        if (wr_drop !== 1'b1 || wr_drop_prior !== 3'd2) begin
            n_fail++;
            $display("FAIL same_queue_still_full: drop=%b prior=%0d expected 1/2", wr_drop, wr_drop_prior);
        end
    endtask

    task automatic test_total_limit();
        apply_reset(1'b0);
        for (int q = 0; q < 4; q++)
            for (int k = 0; k < DEPTH; k++) do_cycle(1'b1, 3'(q), 1'b0, 3'd0);
        n_tests++;
        if (total_cnt !== 8'(TOTAL) || queue_available !== 8'h0F) begin
            n_fail++;
            $display("FAIL total_fill: total=%0d avail=%h expected %0d/0f", total_cnt, queue_available, TOTAL);
        end
        do_cycle(1'b1, 3'd7, 1'b0, 3'd0);
        n_tests++;
        if (wr_drop !== 1'b1 || wr_drop_prior !== 3'd7 || total_cnt !== 8'(TOTAL)) begin
            n_fail++;
            $display("FAIL total_drop: drop=%b prior=%0d total=%0d expected 1/7/%0d", wr_drop, wr_drop_prior, total_cnt, TOTAL);
        end
        do_cycle(1'b1, 3'd7, 1'b1, 3'd0);
        n_tests++;
        if (wr_accept !== 1'b1 || queue_available[7] !== 1'b1 || total_cnt !== 8'(TOTAL)) begin
            n_fail++;
            $display("FAIL total_swap: accept=%b avail=%h total=%0d expected 1/8f/%0d", wr_accept, queue_available, total_cnt, TOTAL);
        end
    endtask

    task automatic test_deq_err();
        apply_reset(1'b0);
        do_cycle(1'b0, 3'd0, 1'b1, 3'd4);
        n_tests++;
        if (deq_err !== 1'b1 || total_cnt !== 8'd0 || queue_available !== 8'h00) begin
            n_fail++;
            $display("FAIL deq_err_empty: err=%b total=%0d avail=%h expected 1/0/00", deq_err, total_cnt, queue_available);
        end
        do_cycle(1'b0, 3'd0, 1'b0, 3'd0);
        n_tests++;
        if (deq_err !== 1'b0) begin
            n_fail++;
            $display("FAIL deq_err_pulse: err=%b expected 0", deq_err);
        end
    endtask

    task automatic test_midreset();
        apply_reset(1'b0);
`ifdef PORT_WR_ADMIT_WATERMARK_EN
        wm_thresh = 6'd8;
`endif
        for (int k = 0; k < 10; k++) do_cycle(1'b1, 3'd1, 1'b0, 3'd0);
`ifdef PORT_WR_ADMIT_WATERMARK_EN
        n_tests++;
        if (queue_almost_full !== 8'h02) begin
            n_fail++;
            $display("FAIL wm_before_reset: got %h expected 02", queue_almost_full);
        end
`endif
        apply_reset(1'b0);
        n_tests++;
        if (queue_available !== 8'h00 || total_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_clear: avail=%h total=%0d expected 00/0", queue_available, total_cnt);
        end
`ifdef PORT_WR_ADMIT_WATERMARK_EN
        n_tests++;
        if (queue_almost_full[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL wm_after_reset: got %b expected 0", queue_almost_full[1]);
        end
`endif
        do_cycle(1'b0, 3'd0, 1'b1, 3'd1);
        n_tests++;
        if (deq_err !== 1'b1 || total_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_empty: err=%b total=%0d expected 1/0", deq_err, total_cnt);
        end
    endtask

    task automatic test_random();
        logic [15:0] got;
        logic [15:0] exp;
        logic wv;
        logic nx;
        logic [2:0] wp;
        logic [2:0] rp;
        apply_reset(1'b0);
        for (int k = 0; k < 3000; k++) begin
`ifdef PORT_WR_ADMIT_WATERMARK_EN
            if (k % 200 == 0) wm_thresh = 6'($urandom_range(0, 40));
`endif
            if (k < 2000) begin
                wv = ($urandom_range(0, 99) < 80);
                nx = ($urandom_range(0, 99) < 35);
            end else begin
                wv = ($urandom_range(0, 99) < 30);
                nx = ($urandom_range(0, 99) < 75);
            end
            wp = ($urandom_range(0, 1) == 0) ? 3'd6 : 3'($urandom_range(0, 7));
            rp = 3'($urandom_range(0, 7));
            do_cycle(wv, wp, nx, rp);
            got = {wr_accept, wr_drop, wr_drop_prior, deq_err, queue_available, total_cnt[1:0]};
            exp = {exp_accept, exp_drop, exp_dprior, exp_deqerr, model_avail(), 2'(m_total)};
            n_tests++;
            if (got !== exp || total_cnt !== 8'(m_total)) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: acc/drop/prio/err/avail=%b total=%0d expected %b total=%0d",
                         k, got[15:2], total_cnt, exp[15:2], m_total);
            end
            n_tests++;
            if (wr_accept === 1'b1 && wr_drop === 1'b1) begin
                n_fail++;
                $display("FAIL random_exclusive_%0d: accept=1 drop=1 expected not both", k);
            end
`ifdef PORT_WR_ADMIT_WATERMARK_EN
            n_tests++;
            if (queue_almost_full !== model_afull()) begin
                n_fail++;
                $display("FAIL random_wm_%0d: got %h expected %h", k, queue_almost_full, model_afull());
            end
`endif
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_prior = 3'd0;
        next     = 1'b0;
        rd_prior = 3'd0;
`ifdef PORT_WR_ADMIT_WATERMARK_EN
        wm_thresh = 6'd8;
`endif
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_total = 0;
        test_reset();
        test_single_enq();
        test_queue_full();
        test_same_queue_deq();
        test_total_limit();
        test_deq_err();
        test_midreset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
